trivium_decryptor: RTL

//  Receive end of the Trivium stream-cipher link: loads an 80-bit key and 80-bit IV, runs the
//  1152-round warm-up, then XORs keystream onto incoming ciphertext bytes to recover plaintext.

---
 rtl/trivium_pkg.sv | 35 +++
 rtl/trivium_core.sv | 42 ++++
 rtl/trivium_decryptor.sv | 101 ++++++++++
 3 files changed

// File: rtl/trivium_pkg.sv
// Shared Trivium definitions: FSM states, state-vector geometry, tap positions,
// key/IV load layout and a single-round update used by both link ends.
package trivium_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, WARMUP, STREAM} state_t;

   localparam int TRIV_LEN   = 288;
   localparam int KS_W       = 8;
   localparam int INIT_RND   = 1152;
   localparam int WARMUP_CYC = INIT_RND / KS_W;

   // Tap positions are 1-based (s1..s288); bit s_i lives at vector index i-1.
   localparam int T1_A = 66,  T1_B = 93,  T1_C = 91,  T1_D = 92,  T1_E = 171;
   localparam int T2_A = 162, T2_B = 177, T2_C = 175, T2_D = 176, T2_E = 264;
   localparam int T3_A = 243, T3_B = 288, T3_C = 286, T3_D = 287, T3_E = 69;

   function automatic logic [TRIV_LEN-1:0] load_state(input logic [79:0] key,
                                                      input logic [79:0] iv);
      return {3'b111, 108'b0, 4'b0, iv, 13'b0, key};
   endfunction

   // Returns {z, next_state} for one round.
   function automatic logic [TRIV_LEN:0] trivium_round(input logic [TRIV_LEN-1:0] s);
      logic t1, t2, t3, z;
      t1 = s[T1_A-1] ^ s[T1_B-1];
      t2 = s[T2_A-1] ^ s[T2_B-1];
      t3 = s[T3_A-1] ^ s[T3_B-1];
      z  = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[T1_C-1] & s[T1_D-1]) ^ s[T1_E-1];
      t2 = t2 ^ (s[T2_C-1] & s[T2_D-1]) ^ s[T2_E-1];
      t3 = t3 ^ (s[T3_C-1] & s[T3_D-1]) ^ s[T3_E-1];
      return {z, s[286:177], t2, s[175:93], t1, s[91:0], t3};
   endfunction

endpackage

// File: rtl/trivium_core.sv
// Trivium state register with W rounds unrolled per clock; z holds the keystream
// bits the next step will consume (bit 0 = first round).
module trivium_core
   import trivium_pkg::*;
#(
   parameter int W = KS_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         step,
   input  logic [79:0]  key,
   input  logic [79:0]  iv,
   output logic [W-1:0] z
);

   logic [TRIV_LEN-1:0] s;
   logic [TRIV_LEN-1:0] s_nxt;
   logic [TRIV_LEN:0]   rnd;

   always_comb begin
      s_nxt = s;
      z     = '0;
      rnd   = '0;
      for (int j = 0; j < W; j++) begin
         rnd      = trivium_round(s_nxt);
         z[j]     = rnd[TRIV_LEN];
         s_nxt    = rnd[TRIV_LEN-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s <= '0;
      end else if (load) begin
         s <= load_state(key, iv);
      end else if (step) begin
         s <= s_nxt;
      end
   end

endmodule

// File: rtl/trivium_decryptor.sv
// Receive-side Trivium: key/IV load, 1152-round warm-up, then XOR keystream onto
// ciphertext bytes through a one-deep valid/ready output register.
module trivium_decryptor
   import trivium_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [79:0] key,
   input  logic [79:0] iv,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic        out_last,
   output logic        busy,
   output logic        err
);

   state_t          state;
   logic [7:0]      warm_cnt;
   logic            last_seen;
   logic [KS_W-1:0] z;
   logic            core_load;
   logic            core_step;
   logic            accept;
   logic            out_xfer;

   assign busy      = (state != IDLE);
   assign in_ready  = (state == STREAM) && !last_seen && (!out_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;
   // Key and IV are captured straight into the cipher state on the accepted start.
   assign core_load = (state == IDLE) && start;
   assign core_step = (state == WARMUP) || accept;

   trivium_core #(.W(KS_W)) u_core (
      .clk  (clk),
      .rst  (rst),
      .load (core_load),
      .step (core_step),
      .key  (key),
      .iv   (iv),
      .z    (z)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         warm_cnt  <= '0;
         last_seen <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         err       <= 1'b0;
      end else begin
         err <= start && busy;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= LOAD;
                  last_seen <= 1'b0;
               end
            end
            LOAD: begin
               state    <= WARMUP;
               warm_cnt <= '0;
            end
            WARMUP: begin
               if (warm_cnt == 8'(WARMUP_CYC - 1)) begin
                  state <= STREAM;
               end else begin
                  warm_cnt <= warm_cnt + 8'd1;
               end
            end
            STREAM: begin
               if (out_xfer) begin
                  out_valid <= 1'b0;
               end
               if (accept) begin
                  out_valid <= 1'b1;
                  out_data  <= in_data ^ z;
                  out_last  <= in_last;
                  if (in_last) begin
                     last_seen <= 1'b1;
                  end
               end
               if (out_xfer && out_last) begin
                  state     <= IDLE;
                  last_seen <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
